uart_key_tx: RTL and testbench



---
 rtl/snake_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 50 +++++
 rtl/uart_key_tx.sv | 164 ++++++++++++++++
 tb/tb_uart_key_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game's UART key path (uart_key_tx, keyboard_driver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the transmitter state encoding, the ASCII direction-key codes and the
// default clock/baud settings. The PARITY state only exists when
// UART_TX_PARITY_EN is defined; the receive side must be built the same way.
package snake_pkg;

    // Default system clock and line rate.
    localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;
    localparam int unsigned DEFAULT_BAUD     = 9600;

    // Direction keys as typed on the host terminal ('1'..'9').
    localparam logic [7:0] KEY_1 = 8'h31;
    localparam logic [7:0] KEY_2 = 8'h32;
    localparam logic [7:0] KEY_3 = 8'h33;
    localparam logic [7:0] KEY_4 = 8'h34;
    localparam logic [7:0] KEY_5 = 8'h35;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h37;
    localparam logic [7:0] KEY_8 = 8'h38;
    localparam logic [7:0] KEY_9 = 8'h39;

    // Transmitter frame states. Encodings are fixed so the parity build and
    // the 8N1 build agree on the values of the shared states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..N-1 and flags the last cycle of each bit.
// Latency: tick is combinational from the count (asserted in cycle N-1 of a bit).
// Backpressure: none; clr holds the count at zero.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, clears the count
//   clr  - synchronous clear; while high the count stays at 0 and tick is low
//   tick - high during the final cycle of an N-cycle bit period
module uart_baud_tick
    import snake_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    // N >= 2 is required by users; guard the width anyway so N=1 still elaborates.
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            // Wrap so the next bit starts at count 0 with no idle cycle.
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_key_tx.sv
// UART byte transmitter: start, 8 data bits LSB first, optional even parity, 1 stop.
// Latency: tx falls in the cycle after the accept edge; frame is 10*N (11*N) cycles.
// Backpressure: data_ready low for the whole frame; upstream holds data_valid/data_in.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset, aborts any frame in flight
//   data_in    - byte to send, captured only on the accept edge
//   data_valid - data_in holds a byte to send
//   data_ready - block can accept a byte (registered, high only in IDLE)
//   tx         - serial line, idle high (registered)
//   busy       - frame in progress (registered)
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frame).
module uart_key_tx
    import snake_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD     = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       busy
);

    // Cycles per bit, truncated.
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;

    tx_state_e  state_q,      state_d;
    logic [7:0] shift_q,      shift_d;
    logic [2:0] bit_idx_q,    bit_idx_d;
    logic       tx_q,         tx_d;
    logic       data_ready_q, data_ready_d;
    logic       busy_q,       busy_d;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed as bits go out, so parity is taken
    // from data_in at accept time and held for the parity slot.
    logic       parity_q,     parity_d;
`endif

    logic accept;
    logic bit_end;

    // Counter is held at zero in IDLE, so the start bit begins at count 0
    // on the cycle after accept.
    uart_baud_tick #(
        .N (BAUD_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .tick (bit_end)
    );

    assign accept = data_valid & data_ready_q;

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = data_in;
                    bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so the line level changes
    // exactly on the edge where a bit boundary is crossed and never between.
    always_comb begin
        tx_d         = 1'b1;
        data_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // Reset takes priority over an accept in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= 8'h00;
            bit_idx_q    <= 3'd0;
            tx_q         <= 1'b1;
            data_ready_q <= 1'b1;
            busy_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_key_tx.sv
// Testbench for uart_key_tx with N = 100/10 = 10 cycles per bit.
// Stimulus pushes expected line frames into a scoreboard; a line monitor
// decodes every frame seen on tx and compares it against the queue head.
module tb_uart_key_tx;
    import snake_pkg::*;

    localparam int N = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expected frames; bit i is the line level during bit time i.
    logic [10:0] sb[$];

    uart_key_tx #(
        .CLK_FREQ (100),
        .BAUD     (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // par is the hand-computed even-parity bit; ignored in the 8N1 build.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par);
        if (NBITS == 11) return {1'b1, par, b, 1'b0};
        else             return {2'b01, b, 1'b0};
    endfunction

    // Line monitor: samples at falling edges, checks each bit is flat for N cycles.
    initial begin : monitor
        logic [10:0] got;
        logic        glitch;
        logic        aborted;
        logic [10:0] exp;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                got     = '0;
                glitch  = 1'b0;
                aborted = 1'b0;
                for (int b = 0; b < NBITS; b++) begin
                    for (int c = 0; c < N; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst === 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) got[b] = tx;
                        else if (tx !== got[b]) glitch = 1'b1;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got 0x%0h, expected no frame", got);
                    end else begin
                        exp = sb.pop_front();
                        check("frame", 32'(got), 32'(exp));
                        check("frame_glitch", 32'(glitch), 32'd0);
                    end
                end
            end
        end
    end

    // Ends at a falling edge with data_ready high, or after a bounded wait.
    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (data_ready !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_ready_wait"}, 32'(data_ready), 32'd1);
    endtask

    // One frame with handshake, busy-length and ready-return timing checks.
    task automatic send_frame(input logic [7:0] b, input logic par, input string tag);
        int busy_cnt;
        int rdy_at;
        wait_ready(tag);
        data_in    = b;
        data_valid = 1'b1;
        sb.push_back(mk_frame(b, par));
        @(posedge clk);
        #1 data_valid = 1'b0;
        busy_cnt = 0;
        rdy_at   = 0;
        for (int i = 1; i <= FRAME + 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (data_ready === 1'b1) begin
                rdy_at = i;
                break;
            end
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(FRAME));
        check({tag, "_ready_return"}, 32'(rdy_at), 32'(FRAME + 1));
    endtask

    initial begin : stimulus
        int bad;
        int i;
        int acc1;
        int acc2;

        // Reset for three cycles, then idle line.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(data_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // '4' = 0011_0100: three ones, even parity 1.
        send_frame(KEY_4, 1'b1, "key4");

        // Back-to-back with data_valid held; data_in changes mid-frame.
        // '8' = 0011_1000 and '2' = 0011_0010 both have three ones.
        wait_ready("b2b");
        data_in    = KEY_8;
        data_valid = 1'b1;
        sb.push_back(mk_frame(KEY_8, 1'b1));
        sb.push_back(mk_frame(KEY_2, 1'b1));
        acc1 = cyc;
        @(posedge clk);
        #1;
        repeat (30) @(negedge clk);
        data_in = KEY_2;
        i = 0;
        @(negedge clk);
        while (data_ready !== 1'b1 && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("b2b_second_ready", 32'(data_ready), 32'd1);
        acc2 = cyc;
        @(posedge clk);
        #1 data_valid = 1'b0;
        check("b2b_period", 32'(acc2 - acc1), 32'(FRAME + 1));

`ifdef UART_TX_PARITY_EN
        // '7' = 0011_0111 has five ones -> parity 1; '1' = 0011_0001 has three -> 1.
        send_frame(KEY_7, 1'b1, "par37");
        send_frame(KEY_1, 1'b1, "par31");
`endif

        // Reset during data bit 3 of 8'h55 (bit time 4 = cycles 41..50 after accept).
        wait_ready("abort");
        data_in    = 8'h55;
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        check("abort_pre_tx_bit3", 32'(tx), 32'd0);
        check("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_ready", 32'(data_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // '6' = 0011_0110: four ones, parity 0.
        send_frame(KEY_6, 1'b0, "key6");

        // Reset and data_valid together: the byte must not be taken.
        wait_ready("rstvld");
        @(posedge clk);
        #1;
        rst        = 1'b1;
        data_in    = KEY_9;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        data_valid = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rstvld_no_frame", 32'(bad), 32'd0);
        check("rstvld_ready", 32'(data_ready), 32'd1);

        // Drain the scoreboard.
        i = 0;
        while (sb.size() != 0 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
